// File: rtl/raycast_pkg.sv
// rtl/raycast_pkg.sv - shared widths, map geometry, screen constants and FSM encoding for the ray caster
package raycast_pkg;

  // Q-format widths
  localparam int POS_W  = 13;  // player position, 1/16 cell
  localparam int ANG_W  = 10;  // direction component, Q2.7
  localparam int ACC_W  = 20;  // ray accumulator, 1/2048 cell
  localparam int DIR_W  = 12;  // per-column ray direction
  localparam int STEP_W = 9;   // march step counter
  localparam int QUOT_W = 11;  // divider dividend/quotient

  // Map geometry: 32x32 cells, cell index is acc[15:11]
  localparam int MAP_BITS = 5;
  localparam int CELL_LSB = 11;

  // Screen constants
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H_PX = 120;
  localparam int CENTER_COL  = SCREEN_W / 2 + 1;

  // Walls this close skip the divider and draw full height
  localparam int NEAR_STEPS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP,
    S_ADDR,
    S_CHECK,
    S_DIVIDE,
    S_DONE,
    S_HOLD
  } state_t;

  // True when the accumulator is negative or at/after the far map edge (512<<7)
  function automatic logic acc_off_map(input logic [ACC_W-1:0] acc);
    return |acc[ACC_W-1:CELL_LSB+MAP_BITS];
  endfunction

endpackage

// File: rtl/slice_divider.sv
// rtl/slice_divider.sv - 11-cycle restoring divider, first iteration taken on the start edge
module slice_divider
  import raycast_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_start,
  input  logic [QUOT_W-1:0] i_dividend,
  input  logic [STEP_W-1:0] i_divisor,
  output logic [QUOT_W-1:0] o_quotient,
  output logic              o_done
);

  logic [STEP_W-1:0] r_rem;
  logic [QUOT_W-1:0] r_quot;
  logic [STEP_W-1:0] r_divisor;
  logic [3:0]        r_count;
  logic              r_busy;
  logic              r_done;

  logic [STEP_W-1:0] w_rem_in;
  logic [QUOT_W-1:0] w_quot_in;
  logic [STEP_W-1:0] w_div_in;
  logic [STEP_W:0]   w_shift;
  logic [STEP_W:0]   w_diff;
  logic              w_fits;
  logic [STEP_W-1:0] w_rem_next;

  // On start the operands come straight from the inputs so iteration 1 happens on that edge
  assign w_rem_in   = i_start ? '0 : r_rem;
  assign w_quot_in  = i_start ? i_dividend : r_quot;
  assign w_div_in   = i_start ? i_divisor : r_divisor;
  assign w_shift    = {w_rem_in, w_quot_in[QUOT_W-1]};
  assign w_diff     = w_shift - {1'b0, w_div_in};
  assign w_fits     = w_shift >= {1'b0, w_div_in};
  assign w_rem_next = w_fits ? w_diff[STEP_W-1:0] : w_shift[STEP_W-1:0];

  // One restoring iteration per cycle; done is raised after the 11th
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (i_start || r_busy) begin
      r_rem     <= w_rem_next;
      r_quot    <= {w_quot_in[QUOT_W-2:0], w_fits};
      r_divisor <= w_div_in;
      r_count   <= i_start ? 4'd1 : r_count + 4'd1;
      r_busy    <= i_start || (r_count != 4'(QUOT_W - 1));
      r_done    <= !i_start && (r_count == 4'(QUOT_W - 1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_quotient = r_quot;
  assign o_done     = r_done;

endmodule

// File: rtl/ray_slice_caster.sv
// rtl/ray_slice_caster.sv - per-column ray march through the wall ROM and step-to-height conversion
module ray_slice_caster
  import raycast_pkg::*;
#(
  parameter int MAX_STEPS = 511,
  parameter int SIZE_K    = 1920,
  parameter int SCREEN_H  = SCREEN_H_PX
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      begin_calc,
  input  logic signed [POS_W-1:0]   playerX,
  input  logic signed [POS_W-1:0]   playerY,
  input  logic signed [ANG_W-1:0]   angle_X,
  input  logic signed [ANG_W-1:0]   angle_Y,
  input  logic [7:0]                column_count,
  output logic [2*MAP_BITS-1:0]     map_addr,
  input  logic                      map_data,
  output logic [6:0]                slice_size,
  output logic                      end_calc
);

  state_t                   r_state;
  logic signed [DIR_W-1:0]  r_dir_x;
  logic signed [DIR_W-1:0]  r_dir_y;
  logic [ACC_W-1:0]         r_acc_x;
  logic [ACC_W-1:0]         r_acc_y;
  logic [STEP_W-1:0]        r_steps;
  logic                     r_oob;
  logic [2*MAP_BITS-1:0]    r_map_addr;
  logic [6:0]               r_slice;
  logic                     r_end_calc;

  // Column offset from screen centre, -80..79
  logic signed [7:0]        w_c;
  logic signed [17:0]       w_c_ext;
  logic signed [17:0]       w_ax_ext;
  logic signed [17:0]       w_ay_ext;
  logic signed [17:0]       w_prod_x;
  logic signed [17:0]       w_prod_y;
  logic signed [17:0]       w_shx;
  logic signed [17:0]       w_shy;
  logic signed [DIR_W-1:0]  w_dir_x;
  logic signed [DIR_W-1:0]  w_dir_y;
  logic                     w_unused;

  logic                     w_hit;
  logic                     w_div_start;
  logic                     w_div_done;
  logic [QUOT_W-1:0]        w_quot;
  logic [6:0]               w_clamped;

  assign w_c      = column_count - 8'(CENTER_COL);
  assign w_c_ext  = {{10{w_c[7]}}, w_c};
  assign w_ax_ext = {{(18-ANG_W){angle_X[ANG_W-1]}}, angle_X};
  assign w_ay_ext = {{(18-ANG_W){angle_Y[ANG_W-1]}}, angle_Y};
  assign w_prod_x = w_c_ext * w_ax_ext;
  assign w_prod_y = w_c_ext * w_ay_ext;
  assign w_shx    = w_prod_x >>> 7;
  assign w_shy    = w_prod_y >>> 7;
  // Rotate the view direction by the column's lateral offset (small-angle approximation)
  assign w_dir_x  = w_ax_ext[DIR_W-1:0] - w_shy[DIR_W-1:0];
  assign w_dir_y  = w_ay_ext[DIR_W-1:0] + w_shx[DIR_W-1:0];
  assign w_unused = ^{w_shx[17:DIR_W], w_shy[17:DIR_W]};

  // The march limit counts as a hit so a ray into open space always terminates
  assign w_hit       = r_oob | map_data | (r_steps == STEP_W'(MAX_STEPS));
  assign w_div_start = (r_state == S_CHECK) && w_hit && (r_steps > STEP_W'(NEAR_STEPS));

  slice_divider u_divider (
    .clock      (clock),
    .resetn     (resetn),
    .i_start    (w_div_start),
    .i_dividend (QUOT_W'(SIZE_K)),
    .i_divisor  (r_steps),
    .o_quotient (w_quot),
    .o_done     (w_div_done)
  );

  // Clamp the quotient into the drawable 1..SCREEN_H range
  always_comb begin
    w_clamped = w_quot[6:0];
    if (w_quot > QUOT_W'(SCREEN_H)) begin
      w_clamped = 7'(SCREEN_H);
    end else if (w_quot == '0) begin
      w_clamped = 7'd1;
    end
  end

  // Control FSM with the march datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_dir_x    <= '0;
      r_dir_y    <= '0;
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_steps    <= '0;
      r_oob      <= 1'b0;
      r_map_addr <= '0;
      r_slice    <= '0;
      r_end_calc <= 1'b0;
    end else begin
      r_end_calc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (begin_calc) r_state <= S_SETUP;
        end
        S_SETUP: begin
          r_dir_x <= w_dir_x;
          r_dir_y <= w_dir_y;
          r_acc_x <= {playerX, 7'b0};
          r_acc_y <= {playerY, 7'b0};
          r_steps <= '0;
          r_state <= S_STEP;
        end
        S_STEP: begin
          r_acc_x <= r_acc_x + {{(ACC_W-DIR_W){r_dir_x[DIR_W-1]}}, r_dir_x};
          r_acc_y <= r_acc_y + {{(ACC_W-DIR_W){r_dir_y[DIR_W-1]}}, r_dir_y};
          r_steps <= r_steps + 1'b1;
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          r_map_addr <= {r_acc_y[CELL_LSB+MAP_BITS-1:CELL_LSB],
                         r_acc_x[CELL_LSB+MAP_BITS-1:CELL_LSB]};
          r_oob      <= acc_off_map(r_acc_x) | acc_off_map(r_acc_y);
          r_state    <= S_CHECK;
        end
        S_CHECK: begin
          if (!w_hit) begin
            r_state <= S_STEP;
          end else if (r_steps <= STEP_W'(NEAR_STEPS)) begin
            r_slice    <= 7'(SCREEN_H);
            r_end_calc <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (w_div_done) begin
            r_slice    <= w_clamped;
            r_end_calc <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (!begin_calc) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign map_addr   = r_map_addr;
  assign slice_size = r_slice;
  assign end_calc   = r_end_calc;

endmodule

// File: tb/tb_ray_slice_caster.sv
// tb/tb_ray_slice_caster.sv - directed scoreboard bench for ray_slice_caster
module tb_ray_slice_caster;

  logic               clock;
  logic               resetn;
  logic               begin_calc;
  logic signed [12:0] playerX;
  logic signed [12:0] playerY;
  logic signed [9:0]  angle_X;
  logic signed [9:0]  angle_Y;
  logic [7:0]         column_count;
  logic [9:0]         map_addr;
  logic               map_data;
  logic [6:0]         slice_size;
  logic               end_calc;

  logic [1023:0]      rom;

  typedef struct {
    int slice;
    int lat;
  } res_t;

  int   addr_q[$];
  res_t res_q[$];
  int   total = 0;
  int   bad = 0;
  int   obs_slice;
  int   obs_lat;
  int   pulses;

  ray_slice_caster dut (
    .clock        (clock),
    .resetn       (resetn),
    .begin_calc   (begin_calc),
    .playerX      (playerX),
    .playerY      (playerY),
    .angle_X      (angle_X),
    .angle_Y      (angle_Y),
    .column_count (column_count),
    .map_addr     (map_addr),
    .map_data     (map_data),
    .slice_size   (slice_size),
    .end_calc     (end_calc)
  );

  assign map_data = rom[map_addr];

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference march: pushes every expected CHECK-cycle address, then the result
  task automatic model(input int px, input int py, input int ax, input int ay, input int col);
    int c, dx, dy, accx, accy, n, addr, q;
    bit oob, hit;
    res_t r;
    c    = col - 81;
    dx   = ax - ((c * ay) >>> 7);
    dy   = ay + ((c * ax) >>> 7);
    accx = px * 128;
    accy = py * 128;
    n    = 0;
    hit  = 0;
    while (!hit) begin
      n++;
      accx += dx;
      accy += dy;
      addr = (((accy >>> 11) & 31) << 5) | ((accx >>> 11) & 31);
      addr_q.push_back(addr);
      oob = (accx < 0) || (accy < 0) || (accx >= 65536) || (accy >= 65536);
      hit = oob || rom[addr] || (n == 511);
    end
    if (n <= 16) begin
      r.slice = 120;
      r.lat   = 2 + 3 * n;
    end else begin
      q = 1920 / n;
      if (q > 120) q = 120;
      if (q < 1) q = 1;
      r.slice = q;
      r.lat   = 13 + 3 * n;
    end
    res_q.push_back(r);
  endtask

  task automatic run_case(input string tag, input int px, input int py, input int ax,
                          input int ay, input int col, input bit drop_early,
                          output int o_slice, output int o_lat);
    res_t exp_r;
    bit   seen;
    int   k;
    int   extra;
    model(px, py, ax, ay, col);
    playerX      = px[12:0];
    playerY      = py[12:0];
    angle_X      = ax[9:0];
    angle_Y      = ay[9:0];
    column_count = col[7:0];
    @(posedge clock);
    #1;
    begin_calc = 1'b1;
    seen    = 0;
    o_slice = -1;
    o_lat   = -1;
    k       = 0;
    while (!seen && k < 3000) begin
      @(posedge clock);
      #1;
      k++;
      if (drop_early && k == 5) begin_calc = 1'b0;
      if (k >= 4 && (k % 3) == 1 && addr_q.size() > 0) begin
        check({tag, "_map_addr"}, int'(map_addr), addr_q.pop_front());
      end
      if (end_calc) begin
        seen    = 1;
        o_slice = int'(slice_size);
        o_lat   = k;
      end
    end
    check({tag, "_end_seen"}, int'(seen), 1);
    check({tag, "_addr_left"}, addr_q.size(), 0);
    addr_q.delete();
    exp_r = res_q.pop_front();
    check({tag, "_slice"}, o_slice, exp_r.slice);
    check({tag, "_latency"}, o_lat, exp_r.lat);
    extra = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (end_calc) extra++;
    end
    check({tag, "_extra_pulse"}, extra, 0);
    begin_calc = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    resetn       = 1'b0;
    begin_calc   = 1'b0;
    playerX      = '0;
    playerY      = '0;
    angle_X      = '0;
    angle_Y      = '0;
    column_count = 8'd81;
    rom          = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_slice", int'(slice_size), 0);
    check("rst_end", int'(end_calc), 0);
    check("rst_addr", int'(map_addr), 0);
    resetn = 1'b1;
    @(posedge clock);

    // Adjacent wall at cell (3,2): near case, no divide
    rom      = '0;
    rom[67]  = 1'b1;
    run_case("near", 40, 40, 128, 0, 81, 0, obs_slice, obs_lat);
    check("near_slice_lit", obs_slice, 120);
    check("near_lat_lit", obs_lat, 26);

    // Wall at cell (5,2): divide path, re-raise after hold
    rom      = '0;
    rom[69]  = 1'b1;
    run_case("far", 40, 40, 128, 0, 81, 0, obs_slice, obs_lat);
    check("far_slice_lit", obs_slice, 48);
    check("far_lat_lit", obs_lat, 133);

    // Empty map looking -x: leaves the map after 41 steps
    rom = '0;
    run_case("oob", 40, 40, -128, 0, 81, 0, obs_slice, obs_lat);
    check("oob_slice_lit", obs_slice, 46);

    // Column 1 skews the ray to dir (128,-80)
    rom = '0;
    run_case("col1", 40, 200, 128, 0, 1, 0, obs_slice, obs_lat);

    // Scattered walls, oblique ray, begin_calc dropped mid-march
    for (int i = 0; i < 1024; i++) rom[i] = ((i % 7) == 0);
    run_case("oblique", 100, 300, -90, 70, 30, 1, obs_slice, obs_lat);

    // Reset mid-march: no pulse, outputs cleared
    rom     = '0;
    rom[69] = 1'b1;
    playerX = 13'sd40;
    playerY = 13'sd40;
    angle_X = 10'sd128;
    angle_Y = 10'sd0;
    column_count = 8'd81;
    @(posedge clock);
    #1;
    begin_calc = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    resetn     = 1'b0;
    begin_calc = 1'b0;
    @(posedge clock);
    #1;
    check("mid_rst_slice", int'(slice_size), 0);
    check("mid_rst_end", int'(end_calc), 0);
    check("mid_rst_addr", int'(map_addr), 0);
    resetn = 1'b1;
    pulses = 0;
    repeat (150) begin
      @(posedge clock);
      #1;
      if (end_calc) pulses++;
    end
    check("mid_rst_no_pulse", pulses, 0);
    run_case("after_rst", 40, 40, 128, 0, 81, 0, obs_slice, obs_lat);
    check("after_rst_slice_lit", obs_slice, 48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
